// File: rtl/aes_serial_io.sv
// aes_serial_io: lane-serial loader and unloader around a block cipher core.
// Input beats assemble key and plaintext; the result is streamed back out.
module aes_serial_io #(
  parameter int LANE_W = 1,
  parameter int BLK_W  = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              EN,
  input  logic [LANE_W-1:0] DIN,
  input  logic [LANE_W-1:0] K_IN,
  input  logic              KEY_KEEP,
  output logic              IN_RDY,
  output logic              core_start,
  output logic [BLK_W-1:0]  core_data,
  output logic [BLK_W-1:0]  core_key,
  input  logic              core_done,
  input  logic [BLK_W-1:0]  core_result,
  output logic [LANE_W-1:0] DOUT,
  output logic              OUT_VAL
);
  localparam int N = BLK_W / LANE_W;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  typedef enum logic [2:0] {
    IDLE, LOAD, START, WAIT, SHIFT
  } state_t;

  state_t state;
  logic [CNT_W-1:0] cnt;
  logic key_keep_r;
  logic [BLK_W-1:0] data_r;
  logic [BLK_W-1:0] key_r;
  logic [BLK_W-1:0] res_r;
  logic [BLK_W-1:0] res_nxt;

  assign res_nxt   = res_r >> LANE_W;
  assign core_data = data_r;
  assign core_key  = key_r;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      key_keep_r <= 1'b0;
      data_r     <= '0;
      key_r      <= '0;
      res_r      <= '0;
      IN_RDY     <= 1'b1;
      core_start <= 1'b0;
      OUT_VAL    <= 1'b0;
      DOUT       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (EN) begin
            data_r[LANE_W-1:0] <= DIN;
            if (!KEY_KEEP)
              key_r[LANE_W-1:0] <= K_IN;
            key_keep_r <= KEY_KEEP;
            cnt <= CNT_W'(1);
            if (N == 1) begin
              state      <= START;
              IN_RDY     <= 1'b0;
              core_start <= 1'b1;
            end else begin
              state <= LOAD;
            end
          end
        end
        LOAD: begin
          if (EN) begin
            data_r[int'(cnt)*LANE_W +: LANE_W] <= DIN;
            if (!key_keep_r)
              key_r[int'(cnt)*LANE_W +: LANE_W] <= K_IN;
            if (cnt == LAST) begin
              state      <= START;
              IN_RDY     <= 1'b0;
              core_start <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        START: begin
          core_start <= 1'b0;
          state      <= WAIT;
        end
        WAIT: begin
          if (core_done) begin
            res_r   <= core_result;
            DOUT    <= core_result[LANE_W-1:0];
            OUT_VAL <= 1'b1;
            cnt     <= '0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (cnt == LAST) begin
            OUT_VAL <= 1'b0;
            DOUT    <= '0;
            IN_RDY  <= 1'b1;
            cnt     <= '0;
            state   <= IDLE;
          end else begin
            res_r <= res_nxt;
            DOUT  <= res_nxt[LANE_W-1:0];
            cnt   <= cnt + 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          IN_RDY  <= 1'b1;
          OUT_VAL <= 1'b0;
        end
      endcase
    end
  end

endmodule
